button_timer_unit: RTL and testbench
====================================

# button_timer_unit

Parametrised successor to the single-button seconds clock. It combines a prescaled free-running counter with N debounced active-low pushbutton channels, and gives each channel a ready/ack handshake with overrun detection. It adds a compare alarm and a status/data read mux with an interrupt output. The block sits between raw board inputs (buttons, system clock) and the CPU-side read/ack logic.

## Interface
- `CNT_W`, 16: count width; must satisfy 1 ≤ `CNT_W` ≤ `DATA_W`.
- `DATA_W`, 16: read-data width.
- `N_BTN`, 4: button channels; must satisfy 2·`N_BTN`+2 ≤ `DATA_W`.
- `PRESCALE`, 4194304: clk cycles per count tick; must be ≥ 2.
- `DEBOUNCE`, 16: consecutive synchronised cycles a new button level must hold; must be ≥ 1.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `btn_n`, in, `N_BTN`: raw asynchronous buttons; 0 = pressed.
- `cnt_en`, in, 1: prescaler/count run enable.
- `cnt_clr`, in, 1: synchronous clear of prescaler, count and wrap flag.
- `alarm_val`, in, `CNT_W`: compare value.
- `ack`, in, `N_BTN`: per-channel acknowledge, level sampled each cycle.
- `alarm_ack`, in, 1: clears the alarm flag.
- `rd_status`, in, 1: 1 selects the status word, 0 selects the count.
- `rdata`, out, `DATA_W`: combinational read mux.
- `irq`, out, 1: OR of all ready bits and the alarm flag.

## Operation
- **Synchroniser.** Two flops per channel; both reset to 1.
- **Debounce (per channel).**
  - State: `deb` (reset 1) and `dcnt` (reset 0).
  - If the synced value equals `deb`: `dcnt` ← 0.
  - Else if `dcnt` = `DEBOUNCE`−1: `deb` ← synced value, `dcnt` ← 0.
  - Else: `dcnt` ← `dcnt`+1.
  - Press event = the edge where `deb` goes 1→0. Release produces no event.
- **Ready (per channel).**
  - Press event sets `ready[i]`.
  - `ack[i]` while `ready[i]`=1 clears `ready[i]` and `ovf[i]`.
  - Press event and `ack[i]` in the same cycle: `ready` stays 1 and `ovf` clears (the new event is kept).
  - Press event while `ready[i]`=1 and no ack: sets `ovf[i]` (sticky).
  - `ack[i]` while `ready[i]`=0: no effect.
- **Prescaler.**
  - `pre` counts 0..`PRESCALE`−1 while `cnt_en`=1 and holds while `cnt_en`=0.
  - `tick` is asserted when `pre` = `PRESCALE`−1 and `cnt_en`=1; `pre` ← 0 on that edge.
- **Count.**
  - On `tick`: `count` ← `count`+1 modulo 2^`CNT_W`.
  - The all-ones→0 transition sets `wrap` (sticky).
  - `cnt_clr` has priority over `tick`: `pre`, `count` and `wrap` ← 0, and the alarm does not fire that cycle.
- **Alarm.**
  - Set on the edge where a tick loads `count` with a value equal to `alarm_val`. Static equality and changes to `alarm_val` do not set it.
  - `alarm_ack` clears it. Set wins over simultaneous `alarm_ack`.
- **rdata.**
  - `rd_status`=0: `count` zero-extended to `DATA_W`.
  - `rd_status`=1: bits [`N_BTN`−1:0] = `ready`; [2·`N_BTN`−1:`N_BTN`] = `ovf`; [2·`N_BTN`] = `wrap`; [2·`N_BTN`+1] = `alarm`; upper bits 0.
- **irq** = |`ready` | `alarm`, combinational from registers.

## Timing
- **Reset values:** all flags, `count`, `pre` and `dcnt` are 0; `deb` and synchroniser flops are 1. Therefore `rdata`=0 and `irq`=0 during and after reset.
- **Reset mid-operation:** asynchronous assertion clears everything immediately, including pending debounce progress.
- **Press latency:** raw `btn_n` is low, stable, and first sampled at edge 1. `ready[i]` and `irq` are high after edge `DEBOUNCE`+2.
- **Glitch rejection:** a low pulse shorter than `DEBOUNCE` synced cycles produces no event.
- **Ack:** `ready` drops on the edge that samples `ack`=1 and is visible the next cycle. Holding `ack` high does not block later events, since set wins.
- **First tick:** occurs on the `PRESCALE`th edge with `cnt_en`=1 after `pre`=0. Ticks then repeat every `PRESCALE` enabled cycles.
- **Read:** `rdata` reflects register state with zero cycles of latency from `rd_status`.

## Test plan
- **Reset:** hold `rst_n`=0 mid-count with `ready` set, then release → `rdata`=0 for both `rd_status` values; `irq`=0.
- **Press/ack** (`DEBOUNCE`=4):
  - hold `btn_n[1]` low → status = 0x0002 after edge 6, not after edge 5;
  - pulse `ack[1]` → status = 0x0000;
  - a 3-cycle glitch on `btn_n[0]` → no `ready`.
- **Overrun:**
  - two presses on ch0 without ack → status = 0x0011;
  - press coinciding with `ack[0]` → status = 0x0001.
- **Count/wrap** (`PRESCALE`=4, `CNT_W`=4):
  - enable for 64 cycles → `count`=0 and `wrap` bit 8 set;
  - `cnt_en`=0 holds the count;
  - `cnt_clr` on a tick cycle → `count`=0.
- **Alarm** (`alarm_val`=3, `PRESCALE`=4):
  - `alarm` bit 9 and `irq` set at the tick loading 3, i.e. edge 12;
  - `alarm_ack` clears it;
  - no re-fire until `count` returns to 3.

Source files
------------

// File: rtl/button_timer_unit.sv
// Debounced active-low pushbutton channels with ready/ack/overrun flags, a prescaled
// wrapping counter with a compare alarm, and a combinational status/count read mux.
module button_timer_unit #(
  parameter int CNT_W    = 16,
  parameter int DATA_W   = 16,
  parameter int N_BTN    = 4,
  parameter int PRESCALE = 4194304,
  parameter int DEBOUNCE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn_n,
  input  logic              cnt_en,
  input  logic              cnt_clr,
  input  logic [CNT_W-1:0]  alarm_val,
  input  logic [N_BTN-1:0]  ack,
  input  logic              alarm_ack,
  input  logic              rd_status,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  localparam int DCNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PRE_W  = $clog2(PRESCALE);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE - 1);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);

  logic [N_BTN-1:0]  r_sync1, r_sync2, r_deb, r_ready, r_ovf, w_press;
  logic [DCNT_W-1:0] r_dcnt [N_BTN];
  logic [PRE_W-1:0]  r_pre;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_wrap, r_alarm, w_tick, w_alarm_set;
  logic [DATA_W-1:0] w_status;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: the per-channel counter array is reset too, so a reset discards half-finished debounces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= '1;
      for (int i = 0; i < N_BTN; i++) r_dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DCNT_MAX) begin
          r_deb[i]  <= r_sync2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the edge on which the debounced level commits from 1 to 0.
  always_comb begin
    for (int i = 0; i < N_BTN; i++)
      w_press[i] = r_deb[i] & ~r_sync2[i] & (r_dcnt[i] == DCNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= '0;
      r_ovf   <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (w_press[i]) begin
          r_ready[i] <= 1'b1;
          if (ack[i] && r_ready[i])  r_ovf[i] <= 1'b0;
          else if (r_ready[i])       r_ovf[i] <= 1'b1;
        end else if (ack[i] && r_ready[i]) begin
          r_ready[i] <= 1'b0;
          r_ovf[i]   <= 1'b0;
        end
      end
    end
  end

  assign w_tick      = cnt_en && (r_pre == PRE_MAX);
  assign w_count_nxt = r_count + 1'b1;
  assign w_alarm_set = w_tick && !cnt_clr && (w_count_nxt == alarm_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (cnt_clr) begin
      r_pre   <= '0;
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (cnt_en) begin
      if (w_tick) begin
        r_pre   <= '0;
        r_count <= w_count_nxt;
        if (&r_count) r_wrap <= 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // Setting beats a simultaneous acknowledge so a fresh match is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_alarm <= 1'b0;
    else if (w_alarm_set) r_alarm <= 1'b1;
    else if (alarm_ack)   r_alarm <= 1'b0;
  end

  // NOTE: default-assign the whole word first so no bit of the combinational mux infers a latch.
  always_comb begin
    w_status                    = '0;
    w_status[N_BTN-1:0]         = r_ready;
    w_status[2*N_BTN-1:N_BTN]   = r_ovf;
    w_status[2*N_BTN]           = r_wrap;
    w_status[2*N_BTN+1]         = r_alarm;
  end

  assign rdata = rd_status ? w_status : DATA_W'(r_count);
  assign irq   = (|r_ready) | r_alarm;

endmodule

// File: tb/tb_button_timer_unit.sv
// Self-checking bench for button_timer_unit: directed scenarios plus randomized traffic,
// compared each cycle against a window/arithmetic reference model.
module tb_button_timer_unit;

  localparam int CNT_W    = 4;
  localparam int DATA_W   = 16;
  localparam int N_BTN    = 4;
  localparam int PRESCALE = 4;
  localparam int DEBOUNCE = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_BTN-1:0]  btn_n, ack;
  logic              cnt_en, cnt_clr, alarm_ack, rd_status;
  logic [CNT_W-1:0]  alarm_val;
  logic [DATA_W-1:0] rdata;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  button_timer_unit #(
    .CNT_W(CNT_W), .DATA_W(DATA_W), .N_BTN(N_BTN), .PRESCALE(PRESCALE), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .alarm_val(alarm_val), .ack(ack), .alarm_ack(alarm_ack), .rd_status(rd_status),
    .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples delayed two edges, a debounced level that flips once the
  // last DEBOUNCE synced samples since the previous flip all disagree with it, and the count
  // derived arithmetically from the number of enabled cycles since the last clear.
  logic [N_BTN-1:0]    m_d1, m_d2, m_deb, m_ready, m_ovf;
  logic [DEBOUNCE-1:0] m_hist [N_BTN];
  int                  m_since [N_BTN];
  int                  m_en_cnt;
  logic                m_alarm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_d1 = '1; m_d2 = '1; m_deb = '1; m_ready = '0; m_ovf = '0;
    for (int i = 0; i < N_BTN; i++) begin
      m_hist[i]  = '0;
      m_since[i] = 0;
    end
    m_en_cnt = 0;
    m_alarm  = 1'b0;
  endtask

  function automatic logic [15:0] exp_count();
    return 16'((m_en_cnt / PRESCALE) % (1 << CNT_W));
  endfunction

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s = '0;
    s[N_BTN-1:0]       = m_ready;
    s[2*N_BTN-1:N_BTN] = m_ovf;
    s[2*N_BTN]         = ((m_en_cnt / PRESCALE) >= (1 << CNT_W));
    s[2*N_BTN+1]       = m_alarm;
    return s;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic m_step();
    logic [N_BTN-1:0] press;
    logic syn, was_ready, set_alarm;
    press = '0;
    for (int i = 0; i < N_BTN; i++) begin
      syn        = m_d2[i];
      m_hist[i]  = {m_hist[i][DEBOUNCE-2:0], syn};
      m_since[i] = m_since[i] + 1;
      if (m_since[i] >= DEBOUNCE && m_hist[i] == {DEBOUNCE{~m_deb[i]}}) begin
        m_deb[i]   = ~m_deb[i];
        m_since[i] = 0;
        press[i]   = ~m_deb[i];
      end
    end
    m_d2 = m_d1;
    m_d1 = btn_n;
    for (int i = 0; i < N_BTN; i++) begin
      was_ready = m_ready[i];
      if (press[i] && was_ready && !ack[i]) m_ovf[i] = 1'b1;
      if (ack[i] && was_ready) begin
        m_ovf[i]   = 1'b0;
        m_ready[i] = 1'b0;
      end
      if (press[i]) m_ready[i] = 1'b1;
    end
    set_alarm = 1'b0;
    if (cnt_clr) begin
      m_en_cnt = 0;
    end else if (cnt_en) begin
      m_en_cnt = m_en_cnt + 1;
      if ((m_en_cnt % PRESCALE) == 0 &&
          ((m_en_cnt / PRESCALE) % (1 << CNT_W)) == int'(alarm_val))
        set_alarm = 1'b1;
    end
    if (set_alarm)      m_alarm = 1'b1;
    else if (alarm_ack) m_alarm = 1'b0;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    m_step();
    rd_status = 1'b0;
    #1 check({tag, "_cnt"}, 32'(rdata), 32'(exp_count()));
    rd_status = 1'b1;
    #1 check({tag, "_sts"}, 32'(rdata), 32'(exp_status()));
    check({tag, "_irq"}, 32'(irq), 32'((|m_ready) | m_alarm));
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  task automatic expect_sts(input string tag, input logic [15:0] v);
    rd_status = 1'b1;
    #1 check(tag, 32'(rdata), 32'(v));
  endtask

  task automatic expect_cnt(input string tag, input logic [15:0] v);
    rd_status = 1'b0;
    #1 check(tag, 32'(rdata), 32'(v));
  endtask

  task automatic expect_zero_in_reset(input string tag);
    rd_status = 1'b0;
    #1 check({tag, "_cnt"}, 32'(rdata), 32'h0);
    rd_status = 1'b1;
    #1 check({tag, "_sts"}, 32'(rdata), 32'h0);
    check({tag, "_irq"}, 32'(irq), 32'h0);
  endtask

  int hold [N_BTN];

  initial begin
    btn_n = '1; ack = '0; cnt_en = 1'b0; cnt_clr = 1'b0; alarm_ack = 1'b0;
    rd_status = 1'b0; alarm_val = '0; rst_n = 1'b0;
    m_reset();
    expect_zero_in_reset("por");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cycle("post_por");

    // Reset mid-operation with a channel ready and the count running.
    cnt_en   = 1'b1;
    btn_n[2] = 1'b0;
    run(10, "pre_rst");
    expect_sts("pre_rst_ready", 16'h0004);
    #2 rst_n = 1'b0;
    m_reset();
    expect_zero_in_reset("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    expect_zero_in_reset("rst_release");
    run(10, "after_rst");
    btn_n[2] = 1'b1;
    cnt_en   = 1'b0;
    run(8, "rel2");
    ack[2] = 1'b1;
    cycle("ack2");
    ack[2]  = 1'b0;
    cnt_clr = 1'b1;
    cycle("clr0");
    cnt_clr = 1'b0;
    expect_sts("idle_clean", 16'h0000);

    // Press latency and acknowledge.
    btn_n[1] = 1'b0;
    run(5, "press");
    expect_sts("press_e5", 16'h0000);
    cycle("press");
    expect_sts("press_e6", 16'h0002);
    check("press_e6_irq", 32'(irq), 32'h1);
    ack[1] = 1'b1;
    cycle("ack1");
    ack[1] = 1'b0;
    expect_sts("ack1_clear", 16'h0000);
    btn_n[1] = 1'b1;
    run(8, "release1");
    expect_sts("release_no_event", 16'h0000);

    // Glitch shorter than the debounce window.
    btn_n[0] = 1'b0;
    run(3, "glitch");
    btn_n[0] = 1'b1;
    run(10, "glitch");
    expect_sts("glitch_rejected", 16'h0000);

    // Overrun, then a press that coincides with an acknowledge.
    btn_n[0] = 1'b0; run(8, "ovf_p1");
    btn_n[0] = 1'b1; run(8, "ovf_r1");
    btn_n[0] = 1'b0; run(8, "ovf_p2");
    expect_sts("overrun", 16'h0011);
    btn_n[0] = 1'b1; run(8, "ovf_r2");
    btn_n[0] = 1'b0;
    run(5, "ack_press");
    ack[0] = 1'b1;
    cycle("ack_press");
    ack[0] = 1'b0;
    expect_sts("press_with_ack", 16'h0001);
    ack[0] = 1'b1;
    cycle("ack0");
    ack[0]   = 1'b0;
    btn_n[0] = 1'b1;
    run(8, "release0");

    // Count, alarm and wrap.
    cnt_clr = 1'b1;
    cycle("clr1");
    cnt_clr   = 1'b0;
    alarm_val = 4'd3;
    cnt_en    = 1'b1;
    run(11, "count");
    expect_sts("alarm_e11", 16'h0000);
    cycle("count");
    expect_sts("alarm_e12", 16'h0200);
    expect_cnt("alarm_e12_cnt", 16'h0003);
    check("alarm_e12_irq", 32'(irq), 32'h1);
    alarm_ack = 1'b1;
    cycle("alarm_ack");
    alarm_ack = 1'b0;
    expect_sts("alarm_cleared", 16'h0000);
    run(51, "count");
    expect_cnt("wrap_count", 16'h0000);
    expect_sts("wrap_no_refire", 16'h0100);
    run(12, "count");
    expect_cnt("refire_count", 16'h0003);
    expect_sts("refire_sts", 16'h0300);
    cnt_en    = 1'b0;
    alarm_ack = 1'b1;
    cycle("hold");
    alarm_ack = 1'b0;
    run(9, "hold");
    expect_cnt("hold_count", 16'h0003);
    cnt_en    = 1'b1;
    alarm_val = 4'd4;
    run(3, "pre_clr");
    cnt_clr = 1'b1;
    cycle("clr_tick");
    cnt_clr = 1'b0;
    expect_cnt("clr_on_tick_cnt", 16'h0000);
    expect_sts("clr_on_tick_sts", 16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < N_BTN; i++) hold[i] = 0;
    for (int k = 0; k < 2000; k++) begin
      if (k == 1000) begin
        #3 rst_n = 1'b0;
        m_reset();
        expect_zero_in_reset("rnd_rst");
        @(negedge clk) rst_n = 1'b1;
      end
      for (int i = 0; i < N_BTN; i++) begin
        if (hold[i] == 0) begin
          btn_n[i] = 1'($urandom_range(0, 1));
          hold[i]  = $urandom_range(1, 9);
        end else begin
          hold[i] = hold[i] - 1;
        end
        ack[i] = ($urandom_range(0, 7) == 0);
      end
      cnt_en    = ($urandom_range(0, 9) != 0);
      cnt_clr   = ($urandom_range(0, 99) == 0);
      alarm_ack = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) alarm_val = CNT_W'($urandom_range(0, 15));
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
